nbit_code_conv_stream: RTL and testbench
========================================

Name: nbit_code_conv_stream

Overview:
- Streaming, parametrised binary/Gray code converter with valid/ready handshakes on both sides.
- Conversion direction is selected per beat: binary-to-Gray or Gray-to-binary.
- A 2-entry output buffer sits between the converter and the consumer, so the block sustains one beat per cycle under back-pressure.
- Successor to the fixed combinational N-bit binary-to-Gray converter; intended for datapaths that need a registered, flow-controlled conversion stage.

Parameters:
- N, 8, data width in bits (N >= 2).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  producer presents a beat.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  N  word to convert.
- in_mode  input  1  0 = binary-to-Gray, 1 = Gray-to-binary; sampled with the beat.
- out_valid  output  1  converted beat available.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  N  converted word.
- out_mode  output  1  mode the head beat was converted with.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. All state is cleared on a clk edge with rst_n = 0.
- Transfers:
  - Input transfer occurs when in_valid & in_ready at a rising edge.
  - Output transfer occurs when out_valid & out_ready at a rising edge.
- Conversion is combinational on in_data before storage:
  - b2g: g[N-1] = b[N-1]; g[i] = b[i+1] ^ b[i].
  - g2b: b[N-1] = g[N-1]; b[i] = b[i+1] ^ g[i] (MSB-down prefix XOR).
  - The converted result is stored together with in_mode.
- Storage: 2-entry FIFO (head, tail) plus an occupancy count 0..2.
- States: EMPTY (count 0), ONE (count 1), FULL (count 2).
- Transitions:
  - EMPTY + push -> ONE.
  - ONE + push, no pop -> FULL.
  - ONE + pop, no push -> EMPTY.
  - ONE + push + pop -> ONE; the new beat becomes head.
  - FULL + pop -> ONE; tail moves to head.
  - FULL never pushes.
- in_ready = (count != 2) & rst_n. It is combinational from the registered count, with no combinational path from out_ready.
- out_valid = (count != 0). out_data and out_mode always show the head entry and are registered outputs.
- Latency: a beat accepted at edge k is visible on out_data after edge k. With EMPTY and out_ready held high, throughput is 1 beat/cycle.
- Ordering: strict FIFO. Modes may change beat to beat with no bubble.
- Stability: while out_valid = 1 and out_ready = 0, out_data and out_mode hold stable.
- Reset values: out_valid = 0, out_data = 0, out_mode = 0, count = 0. in_ready is 0 while rst_n = 0 and 1 in the first cycle after release.
- Reset mid-operation: buffered beats are discarded without being presented. A handshake in the reset cycle is ignored.
- in_data and in_mode are don't-care when in_valid = 0. No X may propagate into storage: store only on push.

Optional Feature:
- Macro: CONV_BEAT_CNT_EN.
- With the macro defined:
  - Extra output port beat_cnt, output, 16 bits.
  - Counts completed output transfers; wraps 16'hFFFF -> 0.
  - Reset value 0; increments by exactly 1 per output transfer.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then b2g single beat: in_data = 8'b00100100, mode 0, out_ready = 1 -> next cycle out_valid = 1, out_data = 8'b00110110, out_mode = 0; EMPTY again one cycle later.
- g2b single beat: in_data = 8'b00110110, mode 1 -> out_data = 8'b00100100, out_mode = 1. Also 8'b11000001 with mode 1 -> 8'b10000001.
- Back-pressure: out_ready = 0; push 8'b10000001 (b2g), then 8'b00001101 (g2b) -> in_ready drops to 0 after the second push, and out_data holds 8'b11000001. A third in_valid is not accepted. Raise out_ready -> outputs 8'b11000001 then 8'b00001001, in order; in_ready returns to 1 after the first pop.
- Streaming: 10 random beats with random mode, out_ready = 1 constantly -> one output per cycle, latency 1. A scoreboard checks the round trip g2b(b2g(x)) == x.
- Simultaneous push/pop in ONE: count stays at 1 and order is preserved. Randomly toggle out_ready for 200 cycles -> no loss, no duplication.
- Reset mid-operation: FULL, then rst_n = 0 for one cycle -> out_valid = 0 and out_data = 0 after the edge, in_ready = 0 during reset and 1 after. With CONV_BEAT_CNT_EN: the count after 65537 transfers equals 1, and beat_cnt = 0 after reset.

Source files
------------

// File: rtl/nbit_code_conv_stream.sv
// nbit_code_conv_stream: per-beat binary<->Gray converter with a 2-entry registered output buffer.
// Optional macro CONV_BEAT_CNT_EN adds a 16-bit count of completed output transfers (beat_cnt).
`default_nettype none

module nbit_code_conv_stream #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         in_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_mode
`ifdef CONV_BEAT_CNT_EN
   ,
   output logic [15:0]  beat_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t       state_q;
   logic [N-1:0] head_data_q;
   logic         head_mode_q;
   logic [N-1:0] tail_data_q;
   logic         tail_mode_q;
   logic [N-1:0] conv_d;
   logic         push;
   logic         pop;

   // Gray-to-binary is a prefix XOR running from the MSB downwards.
   always_comb begin
      conv_d = '0;
      if (in_mode) begin
         conv_d[N-1] = in_data[N-1];
         for (int i = N - 2; i >= 0; i--) begin
            conv_d[i] = conv_d[i+1] ^ in_data[i];
         end
      end else begin
         conv_d = in_data ^ (in_data >> 1);
      end
   end

   assign in_ready  = (state_q != FULL) & rst_n;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = head_data_q;
   assign out_mode  = head_mode_q;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         head_data_q <= '0;
         head_mode_q <= 1'b0;
         tail_data_q <= '0;
         tail_mode_q <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (push) begin
                  head_data_q <= conv_d;
                  head_mode_q <= in_mode;
                  state_q     <= ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  head_data_q <= conv_d;
                  head_mode_q <= in_mode;
               end else if (push) begin
                  tail_data_q <= conv_d;
                  tail_mode_q <= in_mode;
                  state_q     <= FULL;
               end else if (pop) begin
                  state_q <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  head_data_q <= tail_data_q;
                  head_mode_q <= tail_mode_q;
                  state_q     <= ONE;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

`ifdef CONV_BEAT_CNT_EN
   logic [15:0] beat_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_cnt_q <= 16'd0;
      end else if (pop) begin
         beat_cnt_q <= beat_cnt_q + 16'd1;
      end
   end

   assign beat_cnt = beat_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nbit_code_conv_stream.sv
// Self-checking bench for nbit_code_conv_stream: queue-based reference model plus directed literal checks.
`default_nettype none

module tb_nbit_code_conv_stream;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic         in_mode;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;
   logic         out_mode;
`ifdef CONV_BEAT_CNT_EN
   logic [15:0]  beat_cnt;
`endif

   int checks = 0;
   int errors = 0;

   nbit_code_conv_stream #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_mode  (out_mode)
`ifdef CONV_BEAT_CNT_EN
      ,
      .beat_cnt  (beat_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] m_b2g(input logic [N-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [N-1:0] m_g2b(input logic [N-1:0] g);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[i] = ^(g >> i);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [N-1:0] d;
      logic         m;
      logic [N-1:0] orig;
   } beat_t;

   beat_t       q[$];
   logic [15:0] exp_cnt = 16'd0;
   bit          zero_ok = 1'b1;
   int          n_push = 0;
   int          n_dut_pop = 0;

   // Reference model: advances on each rising edge from the pre-edge inputs.
   always @(posedge clk) begin
      bit pu, po;
      beat_t b;
      if (!rst_n) begin
         q.delete();
         exp_cnt = 16'd0;
         zero_ok = 1'b1;
      end else begin
         if (out_valid && out_ready) n_dut_pop++;
         pu = in_valid && (q.size() < 2);
         po = (q.size() > 0) && out_ready;
         if (po) begin
            void'(q.pop_front());
            exp_cnt = exp_cnt + 16'd1;
         end
         if (pu) begin
            b.d    = in_mode ? m_g2b(in_data) : m_b2g(in_data);
            b.m    = in_mode;
            b.orig = in_data;
            q.push_back(b);
            zero_ok = 1'b0;
            n_push++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) chk("in_ready", in_ready, (q.size() < 2));
      else                chk("in_ready_rst", in_ready, 0);
      chk("out_valid", out_valid, (q.size() != 0));
      if (q.size() > 0) begin
         chk("out_data", out_data, q[0].d);
         chk("out_mode", out_mode, q[0].m);
         if (q[0].m) chk("roundtrip_g2b", m_b2g(out_data), q[0].orig);
         else        chk("roundtrip_b2g", m_g2b(out_data), q[0].orig);
      end else if (zero_ok) begin
         chk("out_data_zero", out_data, 0);
         chk("out_mode_zero", out_mode, 0);
      end
`ifdef CONV_BEAT_CNT_EN
      chk("beat_cnt", beat_cnt, exp_cnt);
`endif
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = 1'b0;
      out_ready = 1'b1;

      // model self-pins
      chk("pin_b2g", m_b2g(8'b00100100), 8'b00110110);
      chk("pin_g2b", m_g2b(8'b11000001), 8'b10000001);
      chk("pin_g2b2", m_g2b(8'b00001101), 8'b00001001);

      tick; tick;
      chk("rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_out_data", out_data, 0);
      chk("post_rst_out_mode", out_mode, 0);

      // b2g single beat
      in_valid = 1'b1; in_data = 8'b00100100; in_mode = 1'b0;
      tick;
      in_valid = 1'b0;
      chk("b2g_valid", out_valid, 1);
      chk("b2g_data", out_data, 8'b00110110);
      chk("b2g_mode", out_mode, 0);
      tick;
      chk("b2g_empty", out_valid, 0);

      // g2b single beats
      in_valid = 1'b1; in_data = 8'b00110110; in_mode = 1'b1;
      tick;
      in_valid = 1'b0;
      chk("g2b_data", out_data, 8'b00100100);
      chk("g2b_mode", out_mode, 1);
      tick;
      in_valid = 1'b1; in_data = 8'b11000001; in_mode = 1'b1;
      tick;
      in_valid = 1'b0;
      chk("g2b_data2", out_data, 8'b10000001);
      tick;

      // back-pressure
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'b10000001; in_mode = 1'b0;
      tick;
      chk("bp_ready1", in_ready, 1);
      chk("bp_head1", out_data, 8'b11000001);
      in_data = 8'b00001101; in_mode = 1'b1;
      tick;
      chk("bp_full_ready", in_ready, 0);
      chk("bp_head2", out_data, 8'b11000001);
      in_data = 8'hFF; in_mode = 1'b0;
      tick;
      chk("bp_hold_data", out_data, 8'b11000001);
      chk("bp_hold_ready", in_ready, 0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick;
      chk("bp_second_data", out_data, 8'b00001001);
      chk("bp_second_mode", out_mode, 1);
      chk("bp_ready_back", in_ready, 1);
      tick;
      chk("bp_drained", out_valid, 0);

      // streaming at full rate
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = N'($urandom);
         in_mode  = 1'($urandom);
         tick;
         chk("stream_valid", out_valid, 1);
         chk("stream_ready", in_ready, 1);
      end
      in_valid = 1'b0;
      tick;

      // random traffic with toggling back-pressure
      for (int i = 0; i < 200; i++) begin
         in_valid  = 1'($urandom);
         in_data   = N'($urandom);
         in_mode   = 1'($urandom);
         out_ready = 1'($urandom);
         tick;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick; tick; tick;
      chk("rand_drained", out_valid, 0);
      chk("rand_no_loss", n_dut_pop, n_push);

      // reset while full
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h5A; in_mode = 1'b0;
      tick;
      in_data = 8'hA5; in_mode = 1'b1;
      tick;
      chk("mid_full", in_ready, 0);
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("mid_rst_ready", in_ready, 0);
      tick;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 0);
      rst_n = 1'b1; in_valid = 1'b0;
      #1;
      chk("mid_rel_ready", in_ready, 1);
      tick;

`ifdef CONV_BEAT_CNT_EN
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 65537; i++) begin
         in_data = N'($urandom);
         in_mode = 1'($urandom);
         tick;
      end
      in_valid = 1'b0;
      tick;
      chk("cnt_wrap", beat_cnt, 16'd1);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("cnt_rst", beat_cnt, 16'd0);
      tick;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
